// File: rtl/game_pkg.sv
// Shared constants and FSM encoding for the game scoreboard slice.
package game_pkg;

    localparam int unsigned NUM_PLAYERS       = 4;
    localparam int unsigned PLAYER_W          = 2;
    localparam int unsigned NIBBLE_W          = 4;
    localparam int unsigned RANK_W            = 3;
    localparam int unsigned WIN_THRESHOLD_DEF = 8;

    typedef enum logic [1:0] {
        StArm,
        StSettle,
        StCapture,
        StIdle
    } cap_state_e;

endpackage

// File: rtl/scoreboard_display_scan.sv
// Multiplexed 4-digit display scan: one digit per player, finished players show 4'hF.
module scoreboard_display_scan
    import game_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 2500
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PLAYERS*NIBBLE_W-1:0] pos_flat,
    input  logic [NUM_PLAYERS*RANK_W-1:0]   rank_flat,
    output logic [NUM_PLAYERS-1:0]          digit_sel,
    output logic [NIBBLE_W-1:0]             digit_val
);

    localparam int unsigned       SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [SCAN_W-1:0]   scan_cnt_q;
    logic [PLAYER_W-1:0] idx_q;
    logic [RANK_W-1:0]   cur_rank;
    logic [NIBBLE_W-1:0] cur_pos;

    // Select rank and position of the player under the current digit index.
    always_comb begin
        cur_rank = '0;
        cur_pos  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (idx_q == PLAYER_W'(p)) begin
                cur_rank = rank_flat[p*RANK_W +: RANK_W];
                cur_pos  = pos_flat[p*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // Scan divider; digit index advances (3 wraps to 0) when the divider wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_q + 1'b1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // Registered digit outputs; select and value always move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel <= NUM_PLAYERS'(1);
            digit_val <= '0;
        end else begin
            digit_sel <= NUM_PLAYERS'(1) << idx_q;
            digit_val <= (cur_rank != '0) ? {NIBBLE_W{1'b1}} : cur_pos;
        end
    end

endmodule

// File: rtl/game_scoreboard.sv
// Demultiplexes the time-sliced player stream into per-player registers,
// records finishing order, flags a stalled producer and drives the display scan.
module game_scoreboard
    import game_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SLOT_CYCLES   = 10000,
    parameter int unsigned SCAN_DIV      = 2500,
    parameter int unsigned WIN_THRESHOLD = WIN_THRESHOLD_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PLAYER_W-1:0]             in_player,
    input  logic [NIBBLE_W-1:0]             in_position,
    input  logic [NIBBLE_W-1:0]             in_status_code,
    output logic [NUM_PLAYERS*NIBBLE_W-1:0] pos_flat,
    output logic [NUM_PLAYERS*NIBBLE_W-1:0] status_flat,
    output logic [NUM_PLAYERS*RANK_W-1:0]   rank_flat,
    output logic [RANK_W-1:0]               finish_count,
    output logic                            all_finished,
    output logic                            update_pulse,
    output logic                            stalled,
    output logic [NUM_PLAYERS-1:0]          digit_sel,
    output logic [NIBBLE_W-1:0]             digit_val
);

    localparam int unsigned         SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam int unsigned         STALL_LIMIT = 2 * SLOT_CYCLES;
    localparam int unsigned         STALL_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0]  STALL_MAX   = STALL_W'(STALL_LIMIT);
    localparam logic [RANK_W-1:0]   ALL_DONE    = RANK_W'(NUM_PLAYERS);

    cap_state_e          state_q;
    logic [PLAYER_W-1:0] prev_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [STALL_W-1:0]  stall_cnt_q;
    logic [NIBBLE_W-1:0] pos_q    [NUM_PLAYERS];
    logic [NIBBLE_W-1:0] status_q [NUM_PLAYERS];
    logic [RANK_W-1:0]   rank_q   [NUM_PLAYERS];
    logic                player_change;
    logic                win_now;

    // ARM counts as a change so the first slot after reset is captured.
    assign player_change = (state_q == StArm) || (in_player != prev_q);
    assign win_now       = 32'(in_status_code) > WIN_THRESHOLD;
    assign all_finished  = (finish_count == ALL_DONE);
    assign stalled       = (stall_cnt_q == STALL_MAX);

    // Flatten per-player registers onto the output buses.
    always_comb begin
        pos_flat    = '0;
        status_flat = '0;
        rank_flat   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pos_flat[p*NIBBLE_W +: NIBBLE_W]    = pos_q[p];
            status_flat[p*NIBBLE_W +: NIBBLE_W] = status_q[p];
            rank_flat[p*RANK_W +: RANK_W]       = rank_q[p];
        end
    end

    // Capture FSM: wait for a player change, let the producer settle, capture once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StArm;
            prev_q       <= '0;
            settle_cnt_q <= '0;
            finish_count <= '0;
            update_pulse <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                pos_q[p]    <= '0;
                status_q[p] <= '0;
                rank_q[p]   <= '0;
            end
        end else begin
            update_pulse <= 1'b0;
            unique case (state_q)
                StArm: begin
                    prev_q       <= in_player;
                    settle_cnt_q <= '0;
                    state_q      <= StSettle;
                end
                StIdle: begin
                    if (in_player != prev_q) begin
                        prev_q       <= in_player;
                        settle_cnt_q <= '0;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (in_player != prev_q) begin
                        // Producer moved on again: restart settling for the new index.
                        prev_q       <= in_player;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= StCapture;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                StCapture: begin
                    pos_q[prev_q]    <= in_position;
                    status_q[prev_q] <= in_status_code;
                    update_pulse     <= 1'b1;
                    // Ranks are sticky; only the first win of a player is recorded.
                    if (win_now && rank_q[prev_q] == '0 && finish_count != ALL_DONE) begin
                        rank_q[prev_q] <= finish_count + 1'b1;
                        finish_count   <= finish_count + 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StArm;
            endcase
        end
    end

    // Stall detector: saturating count of cycles since the last player change.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (player_change) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    scoreboard_display_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_display_scan (
        .clk       (clk),
        .rst       (rst),
        .pos_flat  (pos_flat),
        .rank_flat (rank_flat),
        .digit_sel (digit_sel),
        .digit_val (digit_val)
    );

endmodule
